// File: rtl/fp_accum_pkg.sv
// Shared types and constants for the FP32 sequential accumulator.
// Used by fp_accum_seq; no configuration macros live here.
package fp_accum_pkg;

  localparam int FP32_W        = 32;
  localparam int LEN_W_DEFAULT = 11;
  localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage : fp_accum_pkg

// File: rtl/fp_accum_seq.sv
// Sequential FP32 accumulator driving a shared external adder, one element in flight.
// Optional macro FP_ACCUM_BIAS_EN adds a bias input that seeds the accumulator.
module fp_accum_seq
  import fp_accum_pkg::*;
#(
  parameter int ADDER_LAT = 1,
  parameter int LEN_W     = LEN_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
`ifdef FP_ACCUM_BIAS_EN
  input  logic [FP32_W-1:0] bias,
`endif
  input  logic              in_valid,
  input  logic [FP32_W-1:0] in_data,
  output logic              in_ready,
  output logic [FP32_W-1:0] add_a,
  output logic [FP32_W-1:0] add_b,
  input  logic [FP32_W-1:0] add_result,
  output logic              out_valid,
  output logic [FP32_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy
);

  localparam int LAT_W = 3;

  state_t             r_state;
  state_t             w_next;
  logic [FP32_W-1:0]  r_acc;
  logic [FP32_W-1:0]  r_add_a;
  logic [FP32_W-1:0]  r_add_b;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_cnt;
  logic [LAT_W-1:0]   r_lat;
  logic [FP32_W-1:0]  w_init;
  logic [LEN_W-1:0]   w_cnt_inc;
  logic               w_accept;
  logic               w_lat_done;
  logic               w_last;

`ifdef FP_ACCUM_BIAS_EN
  assign w_init = bias;
`else
  assign w_init = FP32_ZERO;
`endif

  assign w_accept   = (r_state == S_ACCUM) && in_valid;
  assign w_lat_done = (r_state == S_WAIT) && (r_lat == LAT_W'(1));
  assign w_cnt_inc  = r_cnt + LEN_W'(1);
  assign w_last     = (w_cnt_inc == r_len);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = (len == '0) ? S_DONE : S_ACCUM;
      S_ACCUM: if (in_valid) w_next = S_WAIT;
      S_WAIT:  if (w_lat_done) w_next = w_last ? S_DONE : S_ACCUM;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc   <= FP32_ZERO;
      r_add_a <= FP32_ZERO;
      r_add_b <= FP32_ZERO;
      r_len   <= '0;
      r_cnt   <= '0;
      r_lat   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc <= w_init;
            r_len <= len;
            r_cnt <= '0;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_add_a <= r_acc;
            r_add_b <= in_data;
            r_lat   <= LAT_W'(ADDER_LAT);
          end
        end
        S_WAIT: begin
          if (w_lat_done) begin
            r_acc <= add_result;
            r_cnt <= w_cnt_inc;
            r_lat <= '0;
            // Operands return to zero once the adder is no longer in use.
            if (w_last) begin
              r_add_a <= FP32_ZERO;
              r_add_b <= FP32_ZERO;
            end
          end else begin
            r_lat <= r_lat - LAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_ACCUM);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = out_valid ? r_acc : FP32_ZERO;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;

endmodule : fp_accum_seq

// File: tb/tb_fp_accum_seq.sv
// Self-checking bench for fp_accum_seq; acts as the external FP adder and keeps a job-sum model.
// Define FP_ACCUM_BIAS_EN for both bench and RTL to exercise the bias seed.
module tb_fp_accum_seq;

  localparam int LAT   = 1;
  localparam int LEN_W = 11;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [31:0]       bias_r;
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic [31:0]       add_a;
  logic [31:0]       add_b;
  logic [31:0]       add_result;
  logic              out_valid;
  logic [31:0]       out_data;
  logic              out_ready;
  logic              busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          n_acc = 0;
  int          acc_cyc[$];
  logic [31:0] m_acc = 32'h0;
  logic        prev_ov = 1'b0;
  logic [31:0] prev_od = 32'h0;

  fp_accum_seq #(.ADDER_LAT(LAT), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
`ifdef FP_ACCUM_BIAS_EN
    .bias      (bias_r),
`endif
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_result(add_result),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(input logic [31:0] b);
    real r;
    if (b[30:23] == 8'h00) return 0.0;
    r = (1.0 + real'(b[22:0]) / 8388608.0) * pow2(int'(b[30:23]) - 127);
    return b[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic s;
    int   e;
    int   m;
    real  a;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = $rtoi((a - 1.0) * 8388608.0);
    return {s, 8'(e + 127), 23'(m)};
  endfunction

  // Reference FP add: NaN/Inf operands propagate, finite values add exactly for these vectors.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;
    return r2f(f2r(a) + f2r(b));
  endfunction

  assign add_result = fp_add(add_a, add_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model and per-cycle compare: a job starts when start is seen while idle,
  // every accepted element is folded into the running sum.
  always @(negedge clk) begin
    if (!reset) begin
      if (!busy && start) begin
`ifdef FP_ACCUM_BIAS_EN
        m_acc = bias_r;
`else
        m_acc = 32'h0;
`endif
        n_acc = 0;
        acc_cyc.delete();
      end
      if (in_valid && in_ready) begin
        m_acc = fp_add(m_acc, in_data);
        n_acc++;
        acc_cyc.push_back(cyc);
      end
      if (!busy) begin
        check("idle_in_ready", {31'b0, in_ready}, 32'h0);
        check("idle_out_valid", {31'b0, out_valid}, 32'h0);
        check("idle_add_a", add_a, 32'h0);
        check("idle_add_b", add_b, 32'h0);
      end
      if (out_valid) begin
        check("out_data_vs_model", out_data, m_acc);
        check("in_ready_in_done", {31'b0, in_ready}, 32'h0);
        if (prev_ov) check("out_data_hold", out_data, prev_od);
      end
      prev_ov = out_valid;
      prev_od = out_data;
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("wait_idle_timeout", 32'h1, 32'h0);
  endtask

  task automatic start_job(input int n, input logic [31:0] b);
    wait_idle();
    @(posedge clk); #1;
    start  = 1'b1;
    len    = LEN_W'(n);
    bias_r = b;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic feed(input logic [31:0] d, input int gap);
    bit found;
    found    = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin found = 1'b1; break; end
    end
    if (!found) check("feed_timeout", 32'h1, 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 32'h0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_out_valid();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    check("out_valid_timeout", 32'h1, 32'h0);
  endtask

  task automatic finish_job(input string name, input int hold, input logic [31:0] exp);
    wait_out_valid();
    check(name, out_data, exp);
    check({name, "_model"}, m_acc, exp);
    repeat (hold) @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({name, "_back_idle"}, {31'b0, busy}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; bias_r = 32'h0;
    in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h0);
    reset = 1'b0;

    // 1 + 2 + 3 = 6 with in_valid continuously offered
    start_job(3, 32'h0);
    feed(32'h3F80_0000, 0);
    feed(32'h4000_0000, 0);
    feed(32'h4040_0000, 0);
    finish_job("sum3", 0, 32'h40C0_0000);
    check("sum3_count", n_acc, 3);
    check("sum3_gap01", acc_cyc[1] - acc_cyc[0], LAT + 1);
    check("sum3_gap12", acc_cyc[2] - acc_cyc[1], LAT + 1);

    // Zero-length job goes straight to DONE
    start_job(0, 32'h0);
    @(negedge clk);
    check("len0_done_next", {31'b0, out_valid}, 32'h1);
    finish_job("len0", 0, 32'h0);
    check("len0_count", n_acc, 0);

    // Sparse input plus back-pressure on the result
    start_job(2, 32'h0);
    feed(32'h3F80_0000, 5);
    feed(32'h4000_0000, 5);
    finish_job("sum2_bp", 4, 32'h4040_0000);
    check("sum2_bp_count", n_acc, 2);

    // Reset during WAIT of element 2 of 3
    start_job(3, 32'h0);
    feed(32'h3F80_0000, 0);
    feed(32'h4000_0000, 0);
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_add_a", add_a, 32'h0);
    check("midrst_add_b", add_b, 32'h0);
    check("midrst_out_valid", {31'b0, out_valid}, 32'h0);
    check("midrst_out_data", out_data, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("postrst_no_out", {31'b0, out_valid}, 32'h0);
    end
    start_job(1, 32'h0);
    feed(32'h40A0_0000, 0);
    finish_job("after_rst", 0, 32'h40A0_0000);

    // start pulsed mid-job must not alter the job length
    start_job(5, 32'h0);
    feed(32'h3F80_0000, 0);
    start = 1'b1;
    len   = LEN_W'(2);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) feed(32'h3F80_0000, 0);
    finish_job("start_ignored", 0, 32'h40A0_0000);
    check("start_ignored_count", n_acc, 5);

    // start coinciding with the DONE handshake is dropped
    start_job(1, 32'h0);
    feed(32'h3F80_0000, 0);
    wait_out_valid();
    @(posedge clk); #1;
    out_ready = 1'b1;
    start     = 1'b1;
    len       = LEN_W'(1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    @(negedge clk);
    check("start_on_done_dropped", {31'b0, busy}, 32'h0);

    // NaN and Inf pass through
    start_job(2, 32'h0);
    feed(32'h7FC0_0000, 0);
    feed(32'h3F80_0000, 0);
    finish_job("nan_pass", 0, 32'h7FC0_0000);
    start_job(1, 32'h0);
    feed(32'h7F80_0000, 0);
    finish_job("inf_pass", 0, 32'h7F80_0000);

`ifdef FP_ACCUM_BIAS_EN
    start_job(1, 32'h3F80_0000);
    feed(32'h3F80_0000, 0);
    finish_job("bias_len1", 0, 32'h4000_0000);
    start_job(0, 32'h4040_0000);
    finish_job("bias_len0", 0, 32'h4040_0000);
`endif

    // Maximum length completes without counter wrap: 2047 x 1.0 = 2047.0
    start_job(2047, 32'h0);
    for (int i = 0; i < 2047; i++) feed(32'h3F80_0000, 0);
    finish_job("len_max", 0, 32'h44FF_E000);
    check("len_max_count", n_acc, 2047);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fp_accum_seq
